// File: rtl/ch_readout_arbiter.sv
// Round-robin arbiter that serializes one channel word per frame: ch_id then data, MSB first.
// Optional even-parity trailer bit enabled by defining CH_READOUT_PARITY_EN.
module ch_readout_arbiter #(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic                iclk,
    input  logic                rstn,
    input  logic                enable,
    input  logic [7:0]          ch_mask,
    input  logic [7:0]          ch_req,
    input  logic [8*DATA_W-1:0] ch_data,
    output logic [7:0]          ch_ack,
    output logic                serial_out,
    output logic                frame_valid,
    output logic                busy,
    output logic [2:0]          last_ch
);

`ifdef CH_READOUT_PARITY_EN
    localparam int F = 4 + DATA_W;
`else
    localparam int F = 3 + DATA_W;
`endif
    localparam int CW = $clog2(F);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t          r_state;
    logic [F-1:0]    r_shreg;
    logic [CW-1:0]   r_cnt;
    logic [GW-1:0]   r_gap;

    logic [7:0]        w_elig;
    logic              w_grant;
    logic [2:0]        w_id;
    logic [2:0]        w_idx;
    logic [DATA_W-1:0] w_data;
    logic [F-1:0]      w_frame;

    assign w_elig = ch_req & ~ch_mask & {8{enable}};

    // Search starts one past the last winner, so the last winner has lowest priority.
    always_comb begin
        w_grant = 1'b0;
        w_id    = last_ch;
        w_idx   = '0;
        for (int i = 1; i <= 8; i++) begin
            w_idx = last_ch + 3'(i);
            if (!w_grant && w_elig[w_idx]) begin
                w_grant = 1'b1;
                w_id    = w_idx;
            end
        end
    end

    assign w_data = ch_data[w_id*DATA_W +: DATA_W];

`ifdef CH_READOUT_PARITY_EN
    assign w_frame = {w_id, w_data, ^{w_id, w_data}};
`else
    assign w_frame = {w_id, w_data};
`endif

    // First frame bit is driven directly at grant; the shift register keeps the rest.
    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_gap       <= '0;
            ch_ack      <= '0;
            serial_out  <= 1'b0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            last_ch     <= 3'd7;
        end else begin
            ch_ack <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        ch_ack      <= 8'd1 << w_id;
                        last_ch     <= w_id;
                        serial_out  <= w_frame[F-1];
                        r_shreg     <= {w_frame[F-2:0], 1'b0};
                        r_cnt       <= CW'(F - 1);
                        frame_valid <= 1'b1;
                        busy        <= 1'b1;
                        r_state     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt == '0) begin
                        serial_out  <= 1'b0;
                        frame_valid <= 1'b0;
                        if (GAP_CYCLES > 0) begin
                            r_gap   <= GAP_LOAD;
                            r_state <= S_GAP;
                        end else begin
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        serial_out <= r_shreg[F-1];
                        r_shreg    <= {r_shreg[F-2:0], 1'b0};
                        r_cnt      <= r_cnt - CW'(1);
                    end
                end
                S_GAP: begin
                    if (r_gap == '0) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap - GW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ch_readout_arbiter.md
# ch_readout_arbiter

Round-robin arbiter and serializer that shares a single serial output line among the eight per-channel readout sources (ch0–ch7) on the PSEC5 digital side. Channels post a data word with a request/acknowledge handshake. The arbiter grants one channel at a time and shifts out a frame containing the channel ID followed by the data word. It runs in the internal clock domain next to the SPI configuration block, and the SPI-programmed channel mask and enable gate it.

## Interface
- DATA_W, 8, width of each channel data word
- GAP_CYCLES, 1, idle cycles inserted after each frame (0 allowed)

- iclk  in  1  internal clock; all logic on rising edge
- rstn  in  1  reset, asynchronous, active-low
- enable  in  1  when low, no new grants; a frame in progress completes
- ch_mask  in  8  bit i high = channel i is never granted
- ch_req  in  8  bit i high = channel i holds a valid word
- ch_data  in  8*DATA_W  channel i word at [i*DATA_W +: DATA_W]
- ch_ack  out  8  one-hot, one-cycle pulse: word of channel i captured
- serial_out  out  1  frame bit stream, MSB first
- frame_valid  out  1  high exactly while serial_out carries frame bits
- busy  out  1  high in SHIFT and GAP states
- last_ch  out  3  ID of the most recently granted channel

## Operation
- Frame = ch_id[2:0] then data[DATA_W-1:0], both MSB first, plus an optional parity bit (see Configuration). Frame length F = 3+DATA_W (+1 with parity).
- Eligible vector: `ch_req & ~ch_mask`, qualified by `enable`. It is evaluated only in IDLE.
- Round-robin rule:
  - The search starts at `last_ch+1` mod 8 and wraps 7→0.
  - The first eligible channel wins.
  - `last_ch` resets to 7, so ch0 has top priority after reset.
- FSM states:
  - IDLE: if any channel is eligible, capture its word into the shift register, load `last_ch`, pulse `ch_ack[i]`, and go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: output one bit per cycle for F cycles. After the last bit, go to GAP if GAP_CYCLES>0, else to IDLE.
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
- Requester obligations:
  - A requester holds `ch_req` and `ch_data` stable until it sees `ch_ack`.
  - A request dropped before grant is not served and leaves no record.
  - `ch_req` sampled in the `ch_ack` cycle is ignored, because the FSM is in SHIFT.
- `ch_mask` and `enable` changes affect only the next IDLE arbitration.
- Deasserting `enable` mid-frame does not truncate the frame.
- Outside frames: `serial_out` = 0 and `frame_valid` = 0.

## Timing
- Reset values: `ch_ack` = 0, `serial_out` = 0, `frame_valid` = 0, `busy` = 0, `last_ch` = 7, FSM = IDLE, shift register = 0.
- Grant latency:
  - Request is eligible at edge k in IDLE.
  - Cycle after edge k: `ch_ack[i]` = 1, `frame_valid` = 1, and `serial_out` = ch_id[2].
  - Last frame bit appears in cycle k+F.
- `ch_ack` is high for exactly one cycle per frame, coincident with the first frame bit.
- Frame-start period for continuously requesting channels: F + GAP_CYCLES + 1 cycles. The IDLE arbitration cycle always shows `frame_valid` = 0.
- `busy` is high from the first frame bit through the last GAP cycle.
- Reset asserted mid-frame:
  - All outputs go to their reset values immediately (asynchronously).
  - The frame is abandoned and not resumed.
  - The interrupted channel's `ch_ack` has already fired, so its word is lost by design.
- All channels masked, or `enable` low: the block stays in IDLE indefinitely with outputs at their idle values.

## Configuration
- Macro `CH_READOUT_PARITY_EN`.
- Defined: one extra bit is appended after data[0]. It is the even parity over ch_id and data, so the total count of ones in the frame is even. F = 4+DATA_W.
- Undefined: no parity bit and F = 3+DATA_W. All other behaviour is identical.

## Test plan
All scenarios use DATA_W=8 and GAP_CYCLES=1.

- Reset:
  - Stimulus: hold `rstn` low, then release with no requests.
  - Required response: all outputs 0 and `last_ch` = 7; `frame_valid` stays 0 for 20 cycles.
- Single request:
  - Stimulus: ch3 requests with data 0xA5, parity disabled.
  - Required response: `ch_ack` = 8'b0000_1000 for 1 cycle; `serial_out` = 0,1,1,1,0,1,0,0,1,0,1 over 11 cycles.
  - With `CH_READOUT_PARITY_EN` defined: a 12th bit of 0 follows.
- Round-robin fairness:
  - Stimulus: all 8 channels request continuously, each with data = channel ID.
  - Required response: grant order 0,1,…,7,0; frame starts every 13 cycles (parity disabled).
- Rotating pointer:
  - Stimulus: ch5 is served; then ch2 and ch7 request together.
  - Required response: ch7 is granted first, then ch2.
- Mask and enable:
  - Stimulus: `ch_mask` = 8'hFF with all requests high.
  - Required response: no ack is issued.
  - Stimulus: drop `enable` mid-frame.
  - Required response: the frame completes all 11 bits, then no further grants.
- Reset mid-frame:
  - Stimulus: assert `rstn` low at frame bit 5.
  - Required response: `serial_out` and `frame_valid` go to 0 in the same cycle; after release, arbitration restarts from ch0.
